fir_tap_loader: RTL and testbench

- Host-side coefficient loader that drives the serial tap-shift port of the team's generic/fixed-tap FIR filters.
- The host writes coefficients by address into an internal NTAPS-entry buffer at any rate, then issues a commit.
- On commit, the block streams the buffer into the FIR's tap chain, one tap per clock, in shift order, and reports busy, loaded and error status.
- It sits between the control bus and the FIR tap-write port (filter tap_wr and tap inputs).

---
 rtl/fir_tap_loader_pkg.sv | 10 +
 rtl/fir_tap_loader_if.sv | 36 +++
 rtl/fir_tap_loader_tap_buffer_ram.sv | 33 +++
 rtl/fir_tap_loader.sv | 137 +++++++++++++
 tb/tb_fir_tap_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_tap_loader_pkg.sv
// Shared types for the FIR coefficient loader: controller state encoding.
package fir_tap_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/fir_tap_loader_if.sv
// Host bus and FIR tap-port signals of the coefficient loader, grouped with
// master (host side) and slave (loader side) views.
interface fir_tap_loader_if
  import fir_tap_loader_pkg::*;
#(
  parameter int NTAPS   = 128,
  parameter int TW      = 16,
  parameter int LGNTAPS = $clog2(NTAPS)
);

  // Strobes are single-cycle level samples, no valid/ready pairing: i_wr and
  // i_commit act only on edges where the loader is IDLE; anything else is
  // dropped (writes flag o_wr_err, commits are silently ignored).
  logic               i_wr;
  logic [LGNTAPS-1:0] i_waddr;
  logic [TW-1:0]      i_wdata;
  logic               i_commit;
  logic               i_clr_err;
  logic               o_tap_wr;
  logic [TW-1:0]      o_tap;
  logic               o_busy;
  logic               o_loaded;
  logic               o_wr_err;
  state_e             o_dbg_state;

  modport master (
    output i_wr, i_waddr, i_wdata, i_commit, i_clr_err,
    input  o_tap_wr, o_tap, o_busy, o_loaded, o_wr_err, o_dbg_state
  );

  modport slave (
    input  i_wr, i_waddr, i_wdata, i_commit, i_clr_err,
    output o_tap_wr, o_tap, o_busy, o_loaded, o_wr_err, o_dbg_state
  );

endinterface

// File: rtl/fir_tap_loader_tap_buffer_ram.sv
// Coefficient buffer: simple dual-port RAM, one write port, one registered
// read port, no reset so it maps onto block RAM.
module tap_buffer_ram #(
  parameter int DEPTH = 128,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // The controller never reads and writes in the same cycle, so read-first
  // behaviour here still gives write-before-read across cycles.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_tap_loader.sv
// Coefficient loader: buffers host-written taps, then on commit shifts them
// into a FIR tap chain one per clock, h[NTAPS-1] first, h[0] last.
module fir_tap_loader
  import fir_tap_loader_pkg::*;
#(
  parameter int NTAPS   = 128,
  parameter int TW      = 16,
  parameter int LGNTAPS = $clog2(NTAPS)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  fir_tap_loader_if.slave bus
);

  localparam logic [LGNTAPS-1:0] LAST_IDX = LGNTAPS'(NTAPS - 1);

  state_e             state_q, state_d;
  logic [LGNTAPS-1:0] cnt_q, cnt_d;
  logic               rd_vld_q, rd_vld_d;
  logic               fin_q, fin_d;
  logic               tap_wr_q, tap_wr_d;
  logic [TW-1:0]      tap_q, tap_d;
  logic               busy_q, busy_d;
  logic               loaded_q, loaded_d;
  logic               err_q, err_d;

  logic               in_idle;
  logic               addr_ok;
  logic               wr_ok;
  logic               wr_drop;
  logic               commit_ok;
  logic               rd_en;
  logic [TW-1:0]      rd_data;

  generate
    if (NTAPS == (1 << LGNTAPS)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_part_range
      localparam logic [LGNTAPS:0] ADDR_LIM = (LGNTAPS + 1)'(NTAPS);
      assign addr_ok = ({1'b0, bus.i_waddr} < ADDR_LIM);
    end
  endgenerate

  assign in_idle   = (state_q == ST_IDLE);
  assign wr_ok     = bus.i_wr && in_idle && addr_ok;
  assign wr_drop   = bus.i_wr && !wr_ok;
  assign commit_ok = in_idle && bus.i_commit;
  assign rd_en     = (state_q == ST_STREAM);

  tap_buffer_ram #(
    .DEPTH (NTAPS),
    .W     (TW),
    .AW    (LGNTAPS)
  ) u_buf (
    .clk_i   (i_clk),
    .we_i    (wr_ok),
    .waddr_i (bus.i_waddr),
    .wdata_i (bus.i_wdata),
    .re_i    (rd_en),
    .raddr_i (cnt_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      fin_q    <= 1'b0;
      tap_wr_q <= 1'b0;
      tap_q    <= '0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      fin_q    <= fin_d;
      tap_wr_q <= tap_wr_d;
      tap_q    <= tap_d;
      busy_q   <= busy_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // The last read is issued with the counter at 0; FLUSH covers the cycle
  // in which that final registered word reaches the tap output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_ok) begin
          state_d = ST_STREAM;
          cnt_d   = LAST_IDX;
        end
      end
      ST_STREAM: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_vld_d = rd_en;
    fin_d    = (state_q == ST_FLUSH);
    tap_wr_d = rd_vld_q;
    tap_d    = rd_vld_q ? rd_data : tap_q;
    busy_d   = !in_idle || commit_ok;
    loaded_d = loaded_q;
    if (commit_ok) begin
      loaded_d = 1'b0;
    end else if (fin_q) begin
      loaded_d = 1'b1;
    end
    err_d = wr_drop || (err_q && !bus.i_clr_err);
  end

  assign bus.o_tap_wr    = tap_wr_q;
  assign bus.o_tap       = tap_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_loaded    = loaded_q;
  assign bus.o_wr_err    = err_q;
  assign bus.o_dbg_state = state_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: an 8-tap and a 5-tap instance checked against an
// array model of the coefficient buffer and the expected shift sequence.
module tb_fir_tap_loader;
  import fir_tap_loader_pkg::*;

  localparam int TW = 16;
  localparam int NA = 8;
  localparam int LA = 3;
  localparam int NB = 5;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fir_tap_loader_if #(.NTAPS(NA), .TW(TW), .LGNTAPS(LA)) ifa ();
  fir_tap_loader_if #(.NTAPS(NB), .TW(TW), .LGNTAPS(LB)) ifb ();

  fir_tap_loader #(.NTAPS(NA), .TW(TW), .LGNTAPS(LA)) dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifa)
  );

  fir_tap_loader #(.NTAPS(NB), .TW(TW), .LGNTAPS(LB)) dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifb)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] mdl [2][8];
  logic          err_m [2];
  logic          ld_m [2];
  logic [TW-1:0] exp_q[$];

  function automatic int ntaps(input int s);
    return (s != 0) ? NB : NA;
  endfunction

  function automatic logic get_tw(input int s);
    return (s != 0) ? ifb.o_tap_wr : ifa.o_tap_wr;
  endfunction

  function automatic logic [TW-1:0] get_tap(input int s);
    return (s != 0) ? ifb.o_tap : ifa.o_tap;
  endfunction

  function automatic logic get_busy(input int s);
    return (s != 0) ? ifb.o_busy : ifa.o_busy;
  endfunction

  function automatic logic get_ld(input int s);
    return (s != 0) ? ifb.o_loaded : ifa.o_loaded;
  endfunction

  function automatic logic get_err(input int s);
    return (s != 0) ? ifb.o_wr_err : ifa.o_wr_err;
  endfunction

  function automatic state_e get_st(input int s);
    return (s != 0) ? ifb.o_dbg_state : ifa.o_dbg_state;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic drv(input int s, input logic wr, input logic [2:0] a,
                     input logic [TW-1:0] d, input logic cm, input logic clr);
    if (s == 0) begin
      ifa.i_wr = wr; ifa.i_waddr = a; ifa.i_wdata = d;
      ifa.i_commit = cm; ifa.i_clr_err = clr;
    end else begin
      ifb.i_wr = wr; ifb.i_waddr = a; ifb.i_wdata = d;
      ifb.i_commit = cm; ifb.i_clr_err = clr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single IDLE write; clr optionally raised in the same cycle.
  task automatic do_write(input int s, input int a, input logic [TW-1:0] d, input logic clr);
    drv(s, 1'b1, 3'(a), d, 1'b0, clr);
    tick();
    drv(s, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    if (a < ntaps(s)) begin
      mdl[s][a] = d;
      if (clr) err_m[s] = 1'b0;
    end else begin
      err_m[s] = 1'b1;
    end
    chk($sformatf("wr_err s%0d a%0d", s, a), 32'(get_err(s)), 32'(err_m[s]));
    chk($sformatf("loaded_hold s%0d", s), 32'(get_ld(s)), 32'(ld_m[s]));
  endtask

  task automatic clear_err(input int s);
    drv(s, 1'b0, 3'd0, '0, 1'b0, 1'b1);
    tick();
    drv(s, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    err_m[s] = 1'b0;
    chk($sformatf("clr_err s%0d", s), 32'(get_err(s)), 32'(err_m[s]));
  endtask

  // Commit (optionally with a same-cycle write), then watch a fixed window.
  // mid_kind: 0 none, 1 extra commit, 2 write of 0xFFFF to addr 0, at cycle mid_c.
  task automatic run_stream(input int s, input string tag, input int wr_addr,
                            input logic [TW-1:0] wr_data, input int mid_c, input int mid_kind);
    int n;
    int pulses;
    logic [15:0] tw_o, bz_o, ld_o, tw_w, bz_w, ld_w;
    n = ntaps(s);
    pulses = 0;
    tw_o = '0; bz_o = '0; ld_o = '0; tw_w = '0; bz_w = '0; ld_w = '0;
    if (wr_addr >= 0) drv(s, 1'b1, 3'(wr_addr), wr_data, 1'b1, 1'b0);
    else              drv(s, 1'b0, 3'd0, '0, 1'b1, 1'b0);
    tick();
    drv(s, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    if (wr_addr >= 0) begin
      if (wr_addr < n) mdl[s][wr_addr] = wr_data;
      else             err_m[s] = 1'b1;
    end
    exp_q.delete();
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(mdl[s][k]);
    for (int c = 0; c <= n + 5; c++) begin
      if (c > 0) tick();
      tw_o[c] = get_tw(s);
      bz_o[c] = get_busy(s);
      ld_o[c] = get_ld(s);
      tw_w[c] = (c >= 2) && (c <= n + 1);
      bz_w[c] = (c <= n + 1);
      ld_w[c] = (c >= n + 2);
      if (get_tw(s)) begin
        pulses++;
        if (exp_q.size() > 0)
          chk($sformatf("%s tap%0d", tag, pulses), 32'(get_tap(s)), 32'(exp_q.pop_front()));
      end
      if (c == 1) chk({tag, " state_stream"}, 32'(get_st(s)), 32'(ST_STREAM));
      if (c == mid_c) begin
        if (mid_kind == 1) drv(s, 1'b0, 3'd0, '0, 1'b1, 1'b0);
        else if (mid_kind == 2) drv(s, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0);
      end else if (c == mid_c + 1) begin
        drv(s, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      end
    end
    if (mid_kind == 2) err_m[s] = 1'b1;
    ld_m[s] = 1'b1;
    chk({tag, " tap_wr_pattern"}, 32'(tw_o), 32'(tw_w));
    chk({tag, " busy_pattern"}, 32'(bz_o), 32'(bz_w));
    chk({tag, " loaded_pattern"}, 32'(ld_o), 32'(ld_w));
    chk({tag, " pulse_count"}, 32'(pulses), 32'(n));
    chk({tag, " wr_err"}, 32'(get_err(s)), 32'(err_m[s]));
    chk({tag, " state_idle"}, 32'(get_st(s)), 32'(ST_IDLE));
  endtask

  task automatic reset_checks(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s tap_wr s%0d", tag, s), 32'(get_tw(s)), 32'd0);
      chk($sformatf("%s busy s%0d", tag, s), 32'(get_busy(s)), 32'd0);
      chk($sformatf("%s loaded s%0d", tag, s), 32'(get_ld(s)), 32'd0);
      chk($sformatf("%s wr_err s%0d", tag, s), 32'(get_err(s)), 32'd0);
      chk($sformatf("%s tap s%0d", tag, s), 32'(get_tap(s)), 32'd0);
      err_m[s] = 1'b0;
      ld_m[s]  = 1'b0;
    end
  endtask

  initial begin
    int s, n, nw, wa, mk, mc;
    drv(0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    drv(1, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mdl[0][i] = '0;
      mdl[1][i] = '0;
    end

    // Reset values while reset is held.
    #22;
    reset_checks("reset");
    chk("reset state", 32'(get_st(0)), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Ramp h[k]=k+1, stream must be 8..1.
    for (int k = 0; k < NA; k++) do_write(0, k, 16'(k + 1), 1'b0);
    run_stream(0, "ramp", -1, '0, -1, 0);
    do_write(0, 2, 16'($urandom), 1'b0);

    // Write and commit in the same cycle; h[5] is the third tap.
    run_stream(0, "wr_commit", 5, 16'h1234, -1, 0);

    // Write during stream is dropped, h[0] unchanged on the next commit.
    run_stream(0, "wr_in_stream", -1, '0, 3, 2);
    clear_err(0);
    run_stream(0, "after_drop", -1, '0, -1, 0);

    // Commit pulse mid-stream is ignored.
    run_stream(0, "mid_commit", -1, '0, 3, 1);

    // Reset after three streamed taps.
    drv(0, 1'b0, 3'd0, '0, 1'b1, 1'b0);
    tick();
    drv(0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("abort tap_wr_before", 32'(get_tw(0)), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("abort");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort state", 32'(get_st(0)), 32'(ST_IDLE));
    run_stream(0, "post_abort", -1, '0, -1, 0);

    // Five-tap instance: out-of-range addresses.
    for (int k = 0; k < NB; k++) do_write(1, k, 16'($urandom), 1'b0);
    do_write(1, 6, 16'hBEEF, 1'b0);
    run_stream(1, "b_stream", -1, '0, -1, 0);
    do_write(1, 7, 16'h5555, 1'b1);
    clear_err(1);
    run_stream(1, "b_wr_commit", 4, 16'hA5A5, -1, 0);

    // Random traffic on both instances.
    for (int r = 0; r < 12; r++) begin
      s  = int'($urandom_range(0, 1));
      n  = ntaps(s);
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++)
        do_write(s, int'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 3) == 0));
      wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
      mk = int'($urandom_range(0, 2));
      mc = (mk == 0) ? -1 : int'($urandom_range(1, n - 2));
      run_stream(s, $sformatf("rand%0d", r), wa, 16'($urandom), mc, mk);
      if (err_m[s]) clear_err(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
